// File: rtl/frv_bitwise_issue.sv
// Issue/writeback sequencer for the bitwise functional unit: issues one op, waits for the
// result, then writes one (narrow) or two (mror) 32-bit words. Optional: FRV_BITWISE_TIMEOUT_EN.
module frv_bitwise_issue #(
  parameter int TMO_W = 4
) (
  input  logic        g_clk,
  input  logic        g_rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_rs1,
  input  logic [31:0] s_rs2,
  input  logic [31:0] s_rs3,
  input  logic [7:0]  s_bop_lut,
  input  logic [5:0]  s_uop,
  input  logic [4:0]  s_rd,
  input  logic        flush,
  output logic        fu_valid,
  output logic [31:0] fu_rs1,
  output logic [31:0] fu_rs2,
  output logic [31:0] fu_rs3,
  output logic [7:0]  fu_bop_lut,
  output logic [5:0]  fu_uop,
  output logic        fu_flush,
  input  logic [63:0] fu_result,
  input  logic        fu_ready,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_ready,
  output logic        busy,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, EXEC, WB_LO, WB_HI} state_t;

  state_t      state, state_nxt;
  logic [31:0] rs1_q, rs2_q, rs3_q;
  logic [7:0]  lut_q;
  logic [5:0]  uop_q;
  logic [4:0]  rd_q;
  logic [63:0] res_q;
  logic        fu_flush_q;
  logic        handshake, uop_onehot, wide, tmo_fire;

  assign s_ready    = (state == IDLE) && !flush && !g_rst;
  assign handshake  = s_valid && s_ready;
  assign uop_onehot = (s_uop != 6'd0) && ((s_uop & (s_uop - 6'd1)) == 6'd0);
  // uop bit 2 is mror, the only op producing a 64-bit register-pair result.
  assign wide       = uop_q[2];

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (handshake && uop_onehot) state_nxt = EXEC;
      EXEC: begin
        if (flush)         state_nxt = IDLE;
        else if (fu_ready) begin
          // Writes to x0 are skipped: narrow rd=0 finishes here, wide pair 0/1 skips the low half.
          if (wide)        state_nxt = (rd_q[4:1] == 4'd0) ? WB_HI : WB_LO;
          else             state_nxt = (rd_q == 5'd0) ? IDLE : WB_LO;
        end
        else if (tmo_fire) state_nxt = IDLE;
      end
      WB_LO: begin
        if (flush)         state_nxt = IDLE;
        else if (wb_ready) state_nxt = wide ? WB_HI : IDLE;
      end
      WB_HI: if (flush || wb_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      state      <= IDLE;
      fu_flush_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      fu_flush_q <= (state == EXEC) && (flush || tmo_fire);
    end
  end

  // NOTE: data registers are reset too, so the operand and writeback buses never show X.
  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      rs1_q <= '0;
      rs2_q <= '0;
      rs3_q <= '0;
      lut_q <= '0;
      uop_q <= '0;
      rd_q  <= '0;
      res_q <= '0;
    end else begin
      if (handshake) begin
        rs1_q <= s_rs1;
        rs2_q <= s_rs2;
        rs3_q <= s_rs3;
        lut_q <= s_bop_lut;
        uop_q <= s_uop;
        rd_q  <= s_rd;
      end
      if (state == EXEC && fu_ready && !flush) res_q <= fu_result;
    end
  end

`ifdef FRV_BITWISE_TIMEOUT_EN
  // Last count value seen in the (2^TMO_W-1)th consecutive EXEC cycle without fu_ready.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE)                  tmo_cnt <= '0;
      else if (state == EXEC && !fu_ready) tmo_cnt <= tmo_cnt + 1'b1;
      err_q <= tmo_fire;
    end
  end

  assign tmo_fire    = (state == EXEC) && !fu_ready && !flush && (tmo_cnt == TMO_LAST);
  assign err_timeout = err_q;
`else
  assign tmo_fire    = 1'b0;
  // Constant zero for any legal width; TMO_W only sizes the counter when the timeout is built.
  assign err_timeout = (TMO_W == 0);
`endif

  assign fu_valid   = (state == EXEC);
  assign fu_uop     = fu_valid ? uop_q : 6'd0;
  assign fu_rs1     = rs1_q;
  assign fu_rs2     = rs2_q;
  assign fu_rs3     = rs3_q;
  assign fu_bop_lut = lut_q;
  assign fu_flush   = fu_flush_q;

  assign wb_valid = (state == WB_LO) || (state == WB_HI);
  assign wb_rd    = (state == WB_HI) ? {rd_q[4:1], 1'b1} :
                    wide             ? {rd_q[4:1], 1'b0} : rd_q;
  assign wb_data  = (state == WB_HI) ? res_q[63:32] : res_q[31:0];
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_frv_bitwise_issue.sv
// Directed bench for frv_bitwise_issue: issue, writeback, x0 skip, flush, bad uop and timeout.
module tb_frv_bitwise_issue;

  logic        g_clk = 1'b0;
  logic        g_rst;
  logic        s_valid, s_ready;
  logic [31:0] s_rs1, s_rs2, s_rs3;
  logic [7:0]  s_bop_lut;
  logic [5:0]  s_uop;
  logic [4:0]  s_rd;
  logic        flush;
  logic        fu_valid;
  logic [31:0] fu_rs1, fu_rs2, fu_rs3;
  logic [7:0]  fu_bop_lut;
  logic [5:0]  fu_uop;
  logic        fu_flush;
  logic [63:0] fu_result;
  logic        fu_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        busy, err_timeout;

  logic auto_ready, man_ready;
  int   vectors = 0;
  int   miscompares = 0;

  // auto_ready models a single-cycle unit (fu_ready follows fu_valid).
  assign fu_ready = auto_ready ? fu_valid : man_ready;

  always #5 g_clk = ~g_clk;

  frv_bitwise_issue #(.TMO_W(4)) dut (
    .g_clk(g_clk), .g_rst(g_rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_rs1(s_rs1), .s_rs2(s_rs2), .s_rs3(s_rs3),
    .s_bop_lut(s_bop_lut), .s_uop(s_uop), .s_rd(s_rd),
    .flush(flush),
    .fu_valid(fu_valid), .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_rs3(fu_rs3),
    .fu_bop_lut(fu_bop_lut), .fu_uop(fu_uop), .fu_flush(fu_flush),
    .fu_result(fu_result), .fu_ready(fu_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .busy(busy), .err_timeout(err_timeout)
  );

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] uop, input logic [4:0] rd,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] rs3, input logic [7:0] lut);
    s_valid = 1'b1; s_uop = uop; s_rd = rd;
    s_rs1 = rs1; s_rs2 = rs2; s_rs3 = rs3; s_bop_lut = lut;
  endtask

  task automatic test_reset();
    g_rst = 1'b1; s_valid = 1'b1; flush = 1'b0; wb_ready = 1'b0;
    auto_ready = 1'b0; man_ready = 1'b0; fu_result = '0;
    s_uop = 6'b001000; s_rd = '0; s_rs1 = '0; s_rs2 = '0; s_rs3 = '0; s_bop_lut = '0;
    #3;
    vectors++;
    if ({s_ready, busy, fu_valid, fu_flush, wb_valid, err_timeout, fu_uop} !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0", {s_ready, busy, fu_valid, fu_flush, wb_valid, err_timeout, fu_uop});
    end
    vectors++;
    if ({fu_rs1, fu_rs2, fu_rs3, fu_bop_lut, wb_data, wb_rd} !== 141'd0) begin
      miscompares++;
      $display("FAIL reset_data: got rs1=%h wb_data=%h wb_rd=%0d want 0", fu_rs1, wb_data, wb_rd);
    end
    tick(); tick();
    g_rst = 1'b0; s_valid = 1'b0;
    #1;
    vectors++;
    if ({s_ready, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_release: got s_ready/busy=%b want 10", {s_ready, busy});
    end
  endtask

  task automatic test_cmov();
    auto_ready = 1'b1; fu_result = 64'h0000_0000_DEAD_BEEF;
    issue(6'b001000, 5'd5, 32'hDEAD_BEEF, 32'd1, 32'd0, 8'h00);
    #1;
    vectors++;
    if (s_ready !== 1'b1) begin
      miscompares++; $display("FAIL cmov_s_ready: got %b want 1", s_ready);
    end
    tick(); s_valid = 1'b0; #1;
    vectors++;
    if ({fu_valid, fu_uop, fu_rs1, fu_rs2, wb_valid} !== {1'b1, 6'b001000, 32'hDEAD_BEEF, 32'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL cmov_exec: got v=%b uop=%b rs1=%h rs2=%h wb=%b want 1 001000 deadbeef 1 0",
               fu_valid, fu_uop, fu_rs1, fu_rs2, wb_valid);
    end
    tick();
    vectors++;
    if ({fu_valid, wb_valid, wb_rd, wb_data} !== {1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL cmov_wb: got fv=%b v=%b rd=%0d data=%h want 0 1 5 deadbeef", fu_valid, wb_valid, wb_rd, wb_data);
    end
    wb_ready = 1'b1; tick(); wb_ready = 1'b0; #1;
    vectors++;
    if ({wb_valid, busy, s_ready} !== 3'b001) begin
      miscompares++; $display("FAIL cmov_done: got %b want 001", {wb_valid, busy, s_ready});
    end
  endtask

  task automatic test_wide_stall();
    auto_ready = 1'b1; fu_result = 64'h1122_3344_5566_7788;
    issue(6'b000100, 5'd7, 32'h0, 32'h0, 32'h1234_5678, 8'hA5);
    tick(); s_valid = 1'b0; #1;
    vectors++;
    if ({fu_valid, fu_uop, fu_rs3, fu_bop_lut} !== {1'b1, 6'b000100, 32'h1234_5678, 8'hA5}) begin
      miscompares++;
      $display("FAIL mror_exec: got uop=%b rs3=%h lut=%h want 000100 12345678 a5", fu_uop, fu_rs3, fu_bop_lut);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      wb_ready = (i == 3);
      #1;
      vectors++;
      if ({wb_valid, wb_rd, wb_data, busy} !== {1'b1, 5'd6, 32'h5566_7788, 1'b1}) begin
        miscompares++;
        $display("FAIL mror_lo_hold%0d: got v=%b rd=%0d data=%h want 1 6 55667788", i, wb_valid, wb_rd, wb_data);
      end
      tick();
    end
    vectors++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd7, 32'h1122_3344}) begin
      miscompares++;
      $display("FAIL mror_hi: got v=%b rd=%0d data=%h want 1 7 11223344", wb_valid, wb_rd, wb_data);
    end
    tick(); wb_ready = 1'b0; #1;
    vectors++;
    if ({wb_valid, busy} !== 2'b00) begin
      miscompares++; $display("FAIL mror_done: got %b want 00", {wb_valid, busy});
    end
  endtask

  task automatic test_x0_skip();
    auto_ready = 1'b1; fu_result = 64'hFFFF_FFFF_0BAD_F00D;
    issue(6'b000001, 5'd0, 32'h1, 32'h2, 32'h3, 8'h00);
    tick(); s_valid = 1'b0; #1;
    vectors++;
    if ({fu_valid, wb_valid} !== 2'b10) begin
      miscompares++; $display("FAIL fsl_x0_exec: got %b want 10", {fu_valid, wb_valid});
    end
    tick();
    vectors++;
    if ({fu_valid, wb_valid, busy, s_ready} !== 4'b0001) begin
      miscompares++; $display("FAIL fsl_x0_skip: got %b want 0001", {fu_valid, wb_valid, busy, s_ready});
    end
    fu_result = 64'hCAFE_F00D_1234_5678;
    issue(6'b000100, 5'd1, 32'h0, 32'h0, 32'h0, 8'h00);
    tick(); s_valid = 1'b0; #1;
    vectors++;
    if ({fu_valid, wb_valid} !== 2'b10) begin
      miscompares++; $display("FAIL b2b_mror_exec: got %b want 10", {fu_valid, wb_valid});
    end
    tick();
    vectors++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd1, 32'hCAFE_F00D}) begin
      miscompares++;
      $display("FAIL mror_x1_only: got v=%b rd=%0d data=%h want 1 1 cafef00d", wb_valid, wb_rd, wb_data);
    end
    wb_ready = 1'b1; tick(); wb_ready = 1'b0; #1;
    vectors++;
    if ({wb_valid, busy} !== 2'b00) begin
      miscompares++; $display("FAIL mror_x1_done: got %b want 00", {wb_valid, busy});
    end
  endtask

  task automatic test_flush();
    // Flush while idle blocks the handshake.
    issue(6'b001000, 5'd2, 32'h5, 32'h6, 32'h7, 8'h00);
    flush = 1'b1; #1;
    vectors++;
    if (s_ready !== 1'b0) begin
      miscompares++; $display("FAIL idle_flush_s_ready: got %b want 0", s_ready);
    end
    tick(); s_valid = 1'b0; flush = 1'b0; #1;
    vectors++;
    if ({busy, fu_valid} !== 2'b00) begin
      miscompares++; $display("FAIL idle_flush_no_issue: got %b want 00", {busy, fu_valid});
    end
    // Flush in EXEC with the unit still working.
    auto_ready = 1'b0; man_ready = 1'b0;
    issue(6'b100000, 5'd3, 32'h1, 32'h2, 32'h3, 8'hE8);
    tick(); s_valid = 1'b0; tick();
    flush = 1'b1; #1;
    vectors++;
    if ({fu_valid, fu_flush} !== 2'b10) begin
      miscompares++; $display("FAIL exec_flush_pre: got %b want 10", {fu_valid, fu_flush});
    end
    tick(); flush = 1'b0; #1;
    vectors++;
    if ({fu_flush, fu_valid, wb_valid, busy, s_ready} !== 5'b10001) begin
      miscompares++; $display("FAIL exec_flush: got %b want 10001", {fu_flush, fu_valid, wb_valid, busy, s_ready});
    end
    tick();
    vectors++;
    if ({fu_flush, busy, wb_valid} !== 3'b000) begin
      miscompares++; $display("FAIL exec_flush_pulse: got %b want 000", {fu_flush, busy, wb_valid});
    end
    // Flush and fu_ready together: flush wins, result dropped.
    auto_ready = 1'b1; fu_result = 64'h0000_0000_1357_9BDF;
    issue(6'b010000, 5'd4, 32'h1, 32'h2, 32'h3, 8'h00);
    tick(); s_valid = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0; #1;
    vectors++;
    if ({fu_flush, wb_valid, busy} !== 3'b100) begin
      miscompares++; $display("FAIL flush_vs_ready: got %b want 100", {fu_flush, wb_valid, busy});
    end
    tick();
    vectors++;
    if ({wb_valid, busy} !== 2'b00) begin
      miscompares++; $display("FAIL flush_vs_ready_nowb: got %b want 00", {wb_valid, busy});
    end
    // Flush in WB_HI: low write stands, high write abandoned.
    fu_result = 64'hAAAA_BBBB_CCCC_DDDD;
    issue(6'b000100, 5'd9, 32'h0, 32'h0, 32'h0, 8'h00);
    tick(); s_valid = 1'b0; tick();
    vectors++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd8, 32'hCCCC_DDDD}) begin
      miscompares++;
      $display("FAIL whi_flush_lo: got v=%b rd=%0d data=%h want 1 8 ccccdddd", wb_valid, wb_rd, wb_data);
    end
    wb_ready = 1'b1; tick(); wb_ready = 1'b0; flush = 1'b1; #1;
    vectors++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd9, 32'hAAAA_BBBB}) begin
      miscompares++;
      $display("FAIL whi_flush_hi: got v=%b rd=%0d data=%h want 1 9 aaaabbbb", wb_valid, wb_rd, wb_data);
    end
    tick(); flush = 1'b0; #1;
    vectors++;
    if ({wb_valid, busy, fu_flush} !== 3'b000) begin
      miscompares++; $display("FAIL whi_flush_abandon: got %b want 000", {wb_valid, busy, fu_flush});
    end
    // Flush with wb_ready in WB_LO of a wide op: low write completes, then idle.
    fu_result = 64'h0102_0304_0506_0708;
    issue(6'b000100, 5'd10, 32'h0, 32'h0, 32'h0, 8'h00);
    tick(); s_valid = 1'b0; tick();
    wb_ready = 1'b1; flush = 1'b1; #1;
    vectors++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd10, 32'h0506_0708}) begin
      miscompares++;
      $display("FAIL wlo_flush_ready: got v=%b rd=%0d data=%h want 1 10 05060708", wb_valid, wb_rd, wb_data);
    end
    tick(); wb_ready = 1'b0; flush = 1'b0; #1;
    vectors++;
    if ({wb_valid, busy} !== 2'b00) begin
      miscompares++; $display("FAIL wlo_flush_idle: got %b want 00", {wb_valid, busy});
    end
  endtask

  task automatic test_bad_uop();
    auto_ready = 1'b1; fu_result = 64'h0000_0000_FFFF_0000;
    issue(6'b000011, 5'd2, 32'h1, 32'h2, 32'h3, 8'h00);
    #1;
    vectors++;
    if (s_ready !== 1'b1) begin
      miscompares++; $display("FAIL multihot_s_ready: got %b want 1", s_ready);
    end
    tick(); s_valid = 1'b0; #1;
    vectors++;
    if ({fu_valid, busy, wb_valid, s_ready, fu_uop} !== 10'b0001_000000) begin
      miscompares++; $display("FAIL multihot_consumed: got %b want 0001000000", {fu_valid, busy, wb_valid, s_ready, fu_uop});
    end
    issue(6'b000000, 5'd3, 32'h1, 32'h2, 32'h3, 8'h00);
    tick(); s_valid = 1'b0; #1;
    vectors++;
    if ({fu_valid, busy, wb_valid} !== 3'b000) begin
      miscompares++; $display("FAIL zerohot_consumed: got %b want 000", {fu_valid, busy, wb_valid});
    end
  endtask

  task automatic test_timeout();
    auto_ready = 1'b0; man_ready = 1'b0; fu_result = 64'h0000_0000_7777_8888;
`ifdef FRV_BITWISE_TIMEOUT_EN
    issue(6'b100000, 5'd12, 32'h1, 32'h2, 32'h3, 8'h96);
    tick(); s_valid = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      #1;
      vectors++;
      if ({fu_valid, err_timeout, fu_flush} !== 3'b100) begin
        miscompares++; $display("FAIL tmo_wait%0d: got %b want 100", i, {fu_valid, err_timeout, fu_flush});
      end
      tick();
    end
    vectors++;
    if ({err_timeout, fu_flush, busy, wb_valid, fu_valid} !== 5'b11000) begin
      miscompares++; $display("FAIL tmo_fire: got %b want 11000", {err_timeout, fu_flush, busy, wb_valid, fu_valid});
    end
    tick();
    vectors++;
    if ({err_timeout, fu_flush, wb_valid} !== 3'b000) begin
      miscompares++; $display("FAIL tmo_pulse: got %b want 000", {err_timeout, fu_flush, wb_valid});
    end
    issue(6'b100000, 5'd12, 32'h1, 32'h2, 32'h3, 8'h96);
    tick(); s_valid = 1'b0;
    for (int i = 1; i <= 14; i++) tick();
    man_ready = 1'b1; #1;
    vectors++;
    if (fu_valid !== 1'b1) begin
      miscompares++; $display("FAIL tmo_last_exec: got %b want 1", fu_valid);
    end
    tick(); man_ready = 1'b0; #1;
    vectors++;
    if ({wb_valid, wb_rd, wb_data, err_timeout, fu_flush} !== {1'b1, 5'd12, 32'h7777_8888, 2'b00}) begin
      miscompares++;
      $display("FAIL tmo_ready_wins: got v=%b rd=%0d data=%h err=%b ff=%b want 1 12 77778888 0 0",
               wb_valid, wb_rd, wb_data, err_timeout, fu_flush);
    end
    wb_ready = 1'b1; tick(); wb_ready = 1'b0; #1;
    vectors++;
    if ({busy, err_timeout} !== 2'b00) begin
      miscompares++; $display("FAIL tmo_ready_done: got %b want 00", {busy, err_timeout});
    end
`else
    issue(6'b100000, 5'd12, 32'h1, 32'h2, 32'h3, 8'h96);
    tick(); s_valid = 1'b0;
    repeat (20) tick();
    vectors++;
    if ({fu_valid, err_timeout, busy, fu_flush} !== 4'b1010) begin
      miscompares++; $display("FAIL no_tmo_wait: got %b want 1010", {fu_valid, err_timeout, busy, fu_flush});
    end
    flush = 1'b1; tick(); flush = 1'b0; #1;
    vectors++;
    if ({busy, fu_flush, err_timeout} !== 3'b010) begin
      miscompares++; $display("FAIL no_tmo_flush: got %b want 010", {busy, fu_flush, err_timeout});
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cmov();
    test_wide_stall();
    test_x0_skip();
    test_flush();
    test_bad_uop();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frv_bitwise_issue.md
Name: frv_bitwise_issue

Overview:
Issue and writeback sequencer for the bitwise functional unit. It accepts one decoded bitwise op from the execute stage and drives operands and a one-hot uop to the unit. It waits for the unit's ready, captures the 64-bit result, and returns it to the register file as one 32-bit write, or two writes for wide (mror) results. It is the pipeline-side initiator for the unit's valid/ready/flush interface.

Parameters:
TMO_W, 4, width of execute-timeout counter; timeout fires after 2^TMO_W-1 EXEC cycles (used only with FRV_BITWISE_TIMEOUT_EN).

Ports:
g_clk  in  1  clock, rising edge.
g_rst  in  1  asynchronous, active-high reset.
s_valid  in  1  issue request valid.
s_ready  out  1  issue request accepted when s_valid & s_ready.
s_rs1, s_rs2, s_rs3  in  32 each  source operands.
s_bop_lut  in  8  xc.bop LUT.
s_uop  in  6  one-hot {bop,lut,cmov,mror,fsr,fsl} (bit 5..0).
s_rd  in  5  destination register.
flush  in  1  pipeline flush.
fu_valid  out  1  operands valid to unit.
fu_rs1, fu_rs2, fu_rs3  out  32 each  registered operands.
fu_bop_lut  out  8  registered LUT.
fu_uop  out  6  registered one-hot uop; all zero outside EXEC.
fu_flush  out  1  flush to unit.
fu_result  in  64  unit result.
fu_ready  in  1  unit result valid.
wb_valid  out  1  register write request.
wb_rd  out  5  write address.
wb_data  out  32  write data.
wb_ready  in  1  register file accepts write.
busy  out  1  state != IDLE.
err_timeout  out  1  one-cycle timeout pulse.

Behaviour:
- Reset (asynchronous): state=IDLE; fu_valid, fu_flush, wb_valid, err_timeout=0; fu_uop=0; all data registers=0; busy=0; s_ready=0 while g_rst is high.
- States: IDLE, EXEC, WB_LO, WB_HI.
- s_ready = (state==IDLE) & !flush. A handshake registers the operands, LUT, uop and rd.
- IDLE -> EXEC on handshake when s_uop is one-hot.
- IDLE -> IDLE on handshake when s_uop is zero-hot or multi-hot. The op is consumed with no fu_valid and no write.
- EXEC: fu_valid=1 and fu_uop=the registered uop. When fu_ready=1, capture fu_result into a 64-bit register and go to WB_LO.
- Minimum latency with a single-cycle unit (fu_ready=fu_valid): handshake at cycle 0, EXEC at cycle 1, wb_valid at cycle 2.
- Narrow ops (all except mror): WB_LO writes wb_rd=rd, wb_data=res[31:0]. On wb_ready go to IDLE.
- Wide op (mror):
  - rd[0] is ignored.
  - WB_LO writes {rd[4:1],0} with res[31:0]. On wb_ready go to WB_HI.
  - WB_HI writes {rd[4:1],1} with res[63:32]. On wb_ready go to IDLE.
- Writes to x0 are skipped without asserting wb_valid. For narrow rd=0, EXEC goes directly to IDLE. For wide rd pair 0/1, EXEC goes directly to WB_HI.
- wb_valid, wb_rd and wb_data hold stable until wb_ready. wb_valid never drops without wb_ready except on flush.
- Flush, any state: next state=IDLE; fu_valid and wb_valid deassert next cycle. fu_flush=1 for exactly one cycle if flush is sampled in EXEC.
- Flush in WB_HI abandons the high write; the already-completed low write stands.
- flush and fu_ready in the same EXEC cycle: flush wins and the result is discarded.
- flush and wb_ready in the same cycle: the write completes (the handshake is sampled), then the state goes to IDLE.
- Back-to-back: a new handshake is possible in the cycle after returning to IDLE. There is no overlap.

Optional Feature:
FRV_BITWISE_TIMEOUT_EN:
- Defined:
  - A TMO_W-bit counter clears on entering EXEC and increments each EXEC cycle without fu_ready.
  - At 2^TMO_W-1 with no fu_ready: fu_flush=1 and err_timeout=1 for one cycle, state goes to IDLE, no write.
  - fu_ready in the saturating cycle takes priority over the timeout.
- Undefined: err_timeout is tied 0, there is no counter, and EXEC waits indefinitely.

Test Plan:
- cmov, rs1=0xDEADBEEF, rs2=1, rd=5, unit returns {32'b0,0xDEADBEEF} with ready=valid -> single write x5=0xDEADBEEF; wb_valid asserts 2 cycles after the issue handshake.
- mror, rd=7, fu_result=0x1122334455667788, wb_ready low 3 cycles then high -> write x6=0x55667788 held stable for 4 cycles, then write x7=0x11223344; busy drops afterwards.
- fsl with rd=0 -> fu_valid pulses once, no wb_valid, s_ready returns in the following cycle; then mror with rd=1 -> only x1 is written, with the high word.
- flush asserted during EXEC with fu_ready=0 -> fu_flush one-cycle pulse, IDLE next cycle, no write. Flush in WB_HI -> low write kept, high write absent.
- s_uop=6'b000011 -> consumed, no fu_valid, no wb_valid.
- With FRV_BITWISE_TIMEOUT_EN and TMO_W=4, fu_ready held low -> err_timeout and fu_flush pulse after 15 EXEC cycles, no write. The same stimulus with fu_ready asserted in EXEC cycle 15 -> normal write, no error pulse.
